seg_scan_driver: RTL

- Display back-end downstream of the queen-solver core.
- Accepts a binary result value (e.g. solution count) over a valid/ready handshake and converts it to 4 BCD digits with a sequential double-dabble FSM.
- Time-multiplexes the digits onto a common 7-segment bus: num segment lines, n_mask digit enables.

---
 rtl/seg_scan_driver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Display back-end for the queen-solver result. A 14-bit binary value is
//   taken over a valid/ready handshake. Values above 9999 saturate to 9999
//   and raise ovf. The value is converted to four BCD digits by a sequential
//   double-dabble FSM, then scanned onto a shared 7-segment bus.
//
//   Optional build macro: LZ_BLANK_EN. When it is defined, leading zero
//   digits (3..1) are blanked. Digit 0 is always shown.
//
// Parameters
//   SCAN_DIV   clk cycles each digit is held during scanning (2..65536)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   val        [13:0] binary value to display
//   val_valid  val is presented
//   val_ready  block can accept val this cycle (IDLE only)
//   ovf        last accepted val exceeded 9999
//   num        [6:0] segments {g,f,e,d,c,b,a}, active-low, registered
//   n_mask     [3:0] digit enables, active-low, bit0 = LS digit, registered
module seg_scan_driver #(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] val,
  input  logic        val_valid,
  output logic        val_ready,
  output logic        ovf,
  output logic [6:0]  num,
  output logic [3:0]  n_mask
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // {bcd[15:0], bin[13:0]}: binary bits shift up into the BCD field
  logic [29:0]   shift_q, shift_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   digits_q, digits_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    num_q, num_d;
  logic [3:0]    n_mask_q, n_mask_d;
  logic [29:0]   adj;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F; // unreachable codes show blank
    endcase
    return s;
  endfunction

`ifdef LZ_BLANK_EN
  // Digit k is a leading zero when it and every higher digit are zero.
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] k);
    logic b;
    case (k)
      2'd3:    b = (d[15:12] == 4'd0);
      2'd2:    b = (d[15:8]  == 8'd0);
      2'd1:    b = (d[15:4]  == 12'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  assign val_ready = (state_q == S_IDLE);
  assign ovf       = ovf_q;
  assign num       = num_q;
  assign n_mask    = n_mask_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    adj      = shift_q;

    case (state_q)
      S_IDLE: begin
        if (val_valid) begin
          if (val > 14'd9999) begin
            shift_d = {16'd0, 14'd9999};
            ovf_d   = 1'b1;
          end else begin
            shift_d = {16'd0, val};
            ovf_d   = 1'b0;
          end
          cnt_d   = 4'd13;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        adj     = {bcd_adjust(shift_q[29:14]), shift_q[13:0]};
        shift_d = {adj[28:0], 1'b0};
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = S_DONE;
      end
      S_DONE: begin
        // All four digits change on the same edge so the scan never
        // shows a mix of old and new digits.
        digits_d = shift_q[29:14];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    n_mask_d = ~(4'b0001 << idx_q);
    num_d    = seg_lut(digits_q[{idx_q, 2'b00} +: 4]);
`ifdef LZ_BLANK_EN
    if (lz_blank(digits_q, idx_q)) num_d = 7'h7F;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      num_q    <= 7'h7F;
      n_mask_q <= 4'b1111;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      n_mask_q <= n_mask_d;
    end
  end

endmodule
